// File: rtl/neuron_feeder_pkg.sv
// Shared op-code encodings and load-FSM state type for the neuron feeder.
package neuron_feeder_pkg;

    localparam logic [1:0] OP_LOAD_W = 2'b00;
    localparam logic [1:0] OP_LOAD_I = 2'b01;
    localparam logic [1:0] OP_STEP   = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StLoadW,
        StLoadI
    } state_e;

endpackage

// File: rtl/neuron_feeder_if.sv
// Host-facing command stream and result channel of the neuron feeder.
interface neuron_feeder_if #(
    parameter int unsigned BUS_WIDTH     = 8,
    parameter int unsigned MEMBRANE_BITS = 7
);

    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               in_op;
    logic [BUS_WIDTH-1:0]     in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_spike;
    logic [MEMBRANE_BITS-1:0] out_membrane;

    modport master (
        output in_valid, in_op, in_data, out_ready,
        input  in_ready, out_valid, out_spike, out_membrane
    );

    modport slave (
        input  in_valid, in_op, in_data, out_ready,
        output in_ready, out_valid, out_spike, out_membrane
    );

endinterface

// File: rtl/neuron_feeder_beat_deserializer.sv
// Shadow register plus beat counter that assembles a wide vector from bus-wide beats,
// LSB-first. full_vector_o is the shadow with the current beat merged in, for same-edge commit.
module beat_deserializer #(
    parameter int unsigned Width    = 32,
    parameter int unsigned BusWidth = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic                clear_i,
    input  logic [BusWidth-1:0] data_i,
    output logic [Width-1:0]    full_vector_o,
    output logic                last_o
);

    localparam int unsigned Beats    = Width / BusWidth;
    localparam int unsigned BeatBits = (Beats > 1) ? $clog2(Beats) : 1;

    logic [BeatBits-1:0] beat_q, beat_d, beat_eff;
    logic [Width-1:0]    shadow_q, shadow_d, shadow_eff;

    // A clear in the same cycle as a load makes that load beat 0 of a fresh vector.
    always_comb begin
        beat_eff   = clear_i ? '0 : beat_q;
        shadow_eff = clear_i ? '0 : shadow_q;

        full_vector_o = shadow_eff;
        full_vector_o[beat_eff*BusWidth +: BusWidth] = data_i;

        last_o = load_i && (beat_eff == BeatBits'(Beats - 1));

        beat_d   = beat_eff;
        shadow_d = shadow_eff;
        if (load_i) begin
            shadow_d = full_vector_o;
            beat_d   = last_o ? '0 : beat_eff + BeatBits'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_q   <= '0;
            shadow_q <= '0;
        end else begin
            beat_q   <= beat_d;
            shadow_q <= shadow_d;
        end
    end

endmodule

// File: rtl/neuron_feeder.sv
// Host-side driver for one neuron: deserializes weight/input vectors from a byte stream,
// issues single-cycle steps and returns each step's result on a buffered valid/ready channel.
module neuron_feeder
    import neuron_feeder_pkg::*;
#(
    parameter int unsigned SYNAPSES      = 32,
    parameter int unsigned BUS_WIDTH     = 8,
    parameter int unsigned MEMBRANE_BITS = $clog2(SYNAPSES) + 2,
    parameter int unsigned COUNT_BITS    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    neuron_feeder_if.slave           bus,
    output logic [SYNAPSES-1:0]      weights,
    output logic [SYNAPSES-1:0]      inputs,
    output logic                     neuron_enable,
    input  logic                     neuron_spike,
    input  logic [MEMBRANE_BITS-1:0] neuron_membrane,
    output logic [COUNT_BITS-1:0]    spike_count,
    output logic                     load_error
);

    if (SYNAPSES % BUS_WIDTH != 0) begin : g_bad_width
        $error("SYNAPSES must be a multiple of BUS_WIDTH");
    end

    state_e                   state_q, state_d;
    logic                     err_q, err_d;
    logic [SYNAPSES-1:0]      weights_q, weights_d;
    logic [SYNAPSES-1:0]      inputs_q, inputs_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_spike_q, out_spike_d;
    logic [MEMBRANE_BITS-1:0] out_membrane_q, out_membrane_d;
    logic [COUNT_BITS-1:0]    count_q, count_d;

    logic                in_ready;
    logic                fire;
    logic                step;
    logic                ds_load;
    logic                ds_clear;
    logic                ds_last;
    logic [SYNAPSES-1:0] ds_vector;
    logic                commit_w;
    logic                commit_i;

    assign in_ready      = !out_valid_q || bus.out_ready;
    assign fire          = bus.in_valid && in_ready;
    assign neuron_enable = step;

    // Command decode: drives the deserializer and the error flag.
    always_comb begin
        step     = 1'b0;
        ds_load  = 1'b0;
        ds_clear = 1'b0;
        err_d    = err_q;
        if (fire) begin
            unique case (bus.in_op)
                OP_LOAD_W: begin
                    ds_load = 1'b1;
                    if (state_q == StLoadI) begin
                        ds_clear = 1'b1;
                        err_d    = 1'b1;
                    end
                end
                OP_LOAD_I: begin
                    ds_load = 1'b1;
                    if (state_q == StLoadW) begin
                        ds_clear = 1'b1;
                        err_d    = 1'b1;
                    end
                end
                OP_STEP: begin
                    step = 1'b1;
                    if (state_q != StIdle) begin
                        ds_clear = 1'b1;
                        err_d    = 1'b1;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    beat_deserializer #(
        .Width    (SYNAPSES),
        .BusWidth (BUS_WIDTH)
    ) u_deser (
        .clk           (clk),
        .reset         (reset),
        .load_i        (ds_load),
        .clear_i       (ds_clear),
        .data_i        (bus.in_data),
        .full_vector_o (ds_vector),
        .last_o        (ds_last)
    );

    // Load FSM and commit selection; kept apart from decode so ds_last has no comb loop.
    always_comb begin
        state_d  = state_q;
        commit_w = 1'b0;
        commit_i = 1'b0;
        if (step) begin
            state_d = StIdle;
        end else if (ds_load) begin
            if (bus.in_op == OP_LOAD_W) begin
                commit_w = ds_last;
                state_d  = ds_last ? StIdle : StLoadW;
            end else begin
                commit_i = ds_last;
                state_d  = ds_last ? StIdle : StLoadI;
            end
        end
    end

    always_comb begin
        weights_d      = commit_w ? ds_vector : weights_q;
        inputs_d       = commit_i ? ds_vector : inputs_q;
        out_valid_d    = out_valid_q;
        out_spike_d    = out_spike_q;
        out_membrane_d = out_membrane_q;
        count_d        = count_q;
        if (step) begin
            out_valid_d    = 1'b1;
            out_spike_d    = neuron_spike;
            out_membrane_d = neuron_membrane;
            if (neuron_spike && (count_q != '1)) begin
                count_d = count_q + COUNT_BITS'(1);
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            err_q          <= 1'b0;
            weights_q      <= '0;
            inputs_q       <= '0;
            out_valid_q    <= 1'b0;
            out_spike_q    <= 1'b0;
            out_membrane_q <= '0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            err_q          <= err_d;
            weights_q      <= weights_d;
            inputs_q       <= inputs_d;
            out_valid_q    <= out_valid_d;
            out_spike_q    <= out_spike_d;
            out_membrane_q <= out_membrane_d;
            count_q        <= count_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_spike    = out_spike_q;
    assign bus.out_membrane = out_membrane_q;
    assign weights          = weights_q;
    assign inputs           = inputs_q;
    assign spike_count      = count_q;
    assign load_error       = err_q;

endmodule

// File: tb/tb_neuron_feeder.sv
// Directed, table-driven bench for neuron_feeder plus a 2-bit-counter instance for saturation.
module tb_neuron_feeder;
    import neuron_feeder_pkg::*;

    localparam int W = 0;
    localparam int I = 1;
    localparam int S = 2;
    localparam int R = 3;

    typedef struct {
        logic        rst;
        logic        v;
        logic [1:0]  op;
        logic [7:0]  d;
        logic        ordy;
        logic        spk;
        logic [6:0]  mem;
        logic        e_rdy;
        logic        e_en;
        logic        e_ov;
        logic        e_os;
        logic [6:0]  e_om;
        logic [15:0] e_cnt;
        logic        e_err;
        logic [31:0] e_w;
        logic [31:0] e_i;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [31:0] weights_a, inputs_a, weights_b, inputs_b;
    logic        en_a, en_b;
    logic        neuron_spike;
    logic [6:0]  neuron_membrane;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;
    logic        err_a, err_b;

    int n_checks;
    int n_fail;

    neuron_feeder_if #(.BUS_WIDTH(8), .MEMBRANE_BITS(7)) bus_a ();
    neuron_feeder_if #(.BUS_WIDTH(8), .MEMBRANE_BITS(7)) bus_b ();

    neuron_feeder #(.SYNAPSES(32), .BUS_WIDTH(8), .MEMBRANE_BITS(7), .COUNT_BITS(16)) dut_a (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus_a),
        .weights         (weights_a),
        .inputs          (inputs_a),
        .neuron_enable   (en_a),
        .neuron_spike    (neuron_spike),
        .neuron_membrane (neuron_membrane),
        .spike_count     (cnt_a),
        .load_error      (err_a)
    );

    neuron_feeder #(.SYNAPSES(32), .BUS_WIDTH(8), .MEMBRANE_BITS(7), .COUNT_BITS(2)) dut_b (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus_b),
        .weights         (weights_b),
        .inputs          (inputs_b),
        .neuron_enable   (en_b),
        .neuron_spike    (neuron_spike),
        .neuron_membrane (neuron_membrane),
        .spike_count     (cnt_b),
        .load_error      (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int rst, input int v, input int op, input int d,
                                input int ordy, input int spk, input int mem,
                                input int rdy, input int en, input int ov, input int os,
                                input int om, input int cnt, input int err,
                                input logic [31:0] w, input logic [31:0] i);
        vec_t r;
        r.rst   = rst[0];
        r.v     = v[0];
        r.op    = op[1:0];
        r.d     = d[7:0];
        r.ordy  = ordy[0];
        r.spk   = spk[0];
        r.mem   = mem[6:0];
        r.e_rdy = rdy[0];
        r.e_en  = en[0];
        r.e_ov  = ov[0];
        r.e_os  = os[0];
        r.e_om  = om[6:0];
        r.e_cnt = cnt[15:0];
        r.e_err = err[0];
        r.e_w   = w;
        r.e_i   = i;
        return r;
    endfunction

    task automatic drive_a(input logic v, input logic [1:0] op, input logic [7:0] d,
                           input logic ordy, input logic spk, input logic [6:0] mem);
        bus_a.in_valid  = v;
        bus_a.in_op     = op;
        bus_a.in_data   = d;
        bus_a.out_ready = ordy;
        neuron_spike    = spk;
        neuron_membrane = mem;
    endtask

    vec_t tbl[$];
    vec_t t;

    initial begin
        logic [31:0] w1, i1;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        drive_a(1'b0, OP_LOAD_W, 8'h00, 1'b0, 1'b0, 7'd0);
        bus_b.in_valid  = 1'b0;
        bus_b.in_op     = OP_STEP;
        bus_b.in_data   = 8'h00;
        bus_b.out_ready = 1'b0;

        w1 = 32'h44332211;
        i1 = 32'hFFFFFFFF;
        // rst v op d ordy spk mem | rdy en ov os om cnt err w i
        tbl.push_back(mk(0, 1, W, 'h11, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, W, 'h22, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, W, 'h33, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, W, 'h44, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, w1, 0));
        tbl.push_back(mk(0, 1, I, 'hFF, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, w1, 0));
        tbl.push_back(mk(0, 1, I, 'hFF, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, w1, 0));
        tbl.push_back(mk(0, 1, I, 'hFF, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, w1, 0));
        tbl.push_back(mk(0, 1, I, 'hFF, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, w1, i1));
        // partial weight load interrupted by STEP, then a held STEP under backpressure
        tbl.push_back(mk(0, 1, W, 'hAA, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, w1, i1));
        tbl.push_back(mk(0, 1, W, 'hBB, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, w1, i1));
        tbl.push_back(mk(0, 1, S, 0, 0, 1, 5, 1, 1, 1, 1, 5, 1, 1, w1, i1));
        tbl.push_back(mk(0, 1, S, 0, 0, 0, 2, 0, 0, 1, 1, 5, 1, 1, w1, i1));
        tbl.push_back(mk(0, 1, S, 0, 1, 0, 2, 1, 1, 1, 0, 2, 1, 1, w1, i1));
        tbl.push_back(mk(0, 0, S, 0, 1, 0, 0, 1, 0, 0, 0, 2, 1, 1, w1, i1));
        // reset in the middle of an input load
        tbl.push_back(mk(0, 1, I, 'h01, 1, 0, 0, 1, 0, 0, 0, 2, 1, 1, w1, i1));
        tbl.push_back(mk(0, 1, I, 'h02, 1, 0, 0, 1, 0, 0, 0, 2, 1, 1, w1, i1));
        tbl.push_back(mk(0, 1, I, 'h03, 1, 0, 0, 1, 0, 0, 0, 2, 1, 1, w1, i1));
        tbl.push_back(mk(1, 0, W, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, I, 'hA1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, I, 'hA2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, I, 'hA3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, I, 'hA4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'hA4A3A2A1));
        // op change mid-load restarts the new target at beat 0
        tbl.push_back(mk(0, 1, W, 'h01, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'hA4A3A2A1));
        tbl.push_back(mk(0, 1, W, 'h02, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'hA4A3A2A1));
        tbl.push_back(mk(0, 1, I, 'hC1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 32'hA4A3A2A1));
        tbl.push_back(mk(0, 1, I, 'hC2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 32'hA4A3A2A1));
        tbl.push_back(mk(0, 1, I, 'hC3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 32'hA4A3A2A1));
        tbl.push_back(mk(0, 1, I, 'hC4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 32'hC4C3C2C1));
        // reserved op in the middle of a load leaves the load intact
        tbl.push_back(mk(0, 1, W, 'h10, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 32'hC4C3C2C1));
        tbl.push_back(mk(0, 1, R, 'hEE, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 32'hC4C3C2C1));
        tbl.push_back(mk(0, 1, W, 'h20, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 32'hC4C3C2C1));
        tbl.push_back(mk(0, 1, W, 'h30, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 32'hC4C3C2C1));
        tbl.push_back(mk(0, 1, W, 'h40, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h40302010,
                         32'hC4C3C2C1));
        tbl.push_back(mk(1, 0, W, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, R, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst.in_ready", 32'(bus_a.in_ready), 32'd1);
        chk("rst.enable", 32'(en_a), 32'd0);
        chk("rst.out_valid", 32'(bus_a.out_valid), 32'd0);
        chk("rst.out_spike", 32'(bus_a.out_spike), 32'd0);
        chk("rst.out_membrane", 32'(bus_a.out_membrane), 32'd0);
        chk("rst.spike_count", 32'(cnt_a), 32'd0);
        chk("rst.load_error", 32'(err_a), 32'd0);
        chk("rst.weights", weights_a, 32'd0);
        chk("rst.inputs", inputs_a, 32'd0);
        chk("rst.count_b", 32'(cnt_b), 32'd0);

        for (int n = 0; n < tbl.size(); n++) begin
            t = tbl[n];
            reset = t.rst;
            drive_a(t.v, t.op, t.d, t.ordy, t.spk, t.mem);
            @(negedge clk);
            chk($sformatf("row%0d.in_ready", n), 32'(bus_a.in_ready), 32'(t.e_rdy));
            chk($sformatf("row%0d.enable", n), 32'(en_a), 32'(t.e_en));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d.out_valid", n), 32'(bus_a.out_valid), 32'(t.e_ov));
            chk($sformatf("row%0d.out_spike", n), 32'(bus_a.out_spike), 32'(t.e_os));
            chk($sformatf("row%0d.out_membrane", n), 32'(bus_a.out_membrane), 32'(t.e_om));
            chk($sformatf("row%0d.spike_count", n), 32'(cnt_a), 32'(t.e_cnt));
            chk($sformatf("row%0d.load_error", n), 32'(err_a), 32'(t.e_err));
            chk($sformatf("row%0d.weights", n), weights_a, t.e_w);
            chk($sformatf("row%0d.inputs", n), inputs_a, t.e_i);
        end
        reset = 1'b0;

        // Back-to-back STEPs with the consumer always ready: one result per cycle.
        for (int k = 0; k < 10; k++) begin
            drive_a(1'b1, OP_STEP, 8'h00, 1'b1, 1'b1, 7'(k + 3));
            @(negedge clk);
            chk($sformatf("burst%0d.in_ready", k), 32'(bus_a.in_ready), 32'd1);
            chk($sformatf("burst%0d.enable", k), 32'(en_a), 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("burst%0d.out_valid", k), 32'(bus_a.out_valid), 32'd1);
            chk($sformatf("burst%0d.out_membrane", k), 32'(bus_a.out_membrane), 32'(k + 3));
            chk($sformatf("burst%0d.spike_count", k), 32'(cnt_a), 32'(k + 1));
        end
        drive_a(1'b0, OP_STEP, 8'h00, 1'b1, 1'b0, 7'd0);
        @(posedge clk);
        #1;
        chk("burst.drain_valid", 32'(bus_a.out_valid), 32'd0);
        chk("burst.final_count", 32'(cnt_a), 32'd10);

        // Saturating 2-bit spike counter.
        for (int k = 0; k < 5; k++) begin
            bus_b.in_valid  = 1'b1;
            bus_b.in_op     = OP_STEP;
            bus_b.out_ready = 1'b1;
            neuron_spike    = 1'b1;
            @(negedge clk);
            chk($sformatf("sat%0d.enable", k), 32'(en_b), 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d.spike_count", k), 32'(cnt_b), (k < 3) ? 32'(k + 1) : 32'd3);
        end
        bus_b.in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_feeder.md
# neuron_feeder

Host-side driver for one `neuron` instance.
- Accepts a byte-wide command stream.
- Deserializes the stream into the neuron's weight and input vectors, committing each vector atomically.
- Issues one-cycle integration steps to the neuron.
- Returns each step's spike and membrane result on a buffered valid/ready output channel.
- Sits between the chip I/O interface and the neuron. It writes everything the neuron reads and reads everything the neuron produces.

## Interface
Parameters:
- SYNAPSES, 32, neuron synapse count; must be a multiple of BUS_WIDTH
- BUS_WIDTH, 8, command data width; BEATS = SYNAPSES/BUS_WIDTH
- MEMBRANE_BITS, $clog2(SYNAPSES)+2, neuron membrane width
- COUNT_BITS, 16, spike counter width

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  command beat valid
- in_ready  out  1  command beat accepted when valid&ready
- in_op  in  2  00 LOAD_W, 01 LOAD_I, 10 STEP, 11 reserved
- in_data  in  BUS_WIDTH  payload; ignored for STEP/reserved
- weights  out  SYNAPSES  committed weight vector to neuron
- inputs  out  SYNAPSES  committed input vector to neuron
- neuron_enable  out  1  one-cycle step strobe to neuron
- neuron_spike  in  1  neuron is_spike (combinational)
- neuron_membrane  in  MEMBRANE_BITS  neuron new_membrane (combinational)
- out_valid  out  1  result available
- out_ready  in  1  result consumed when valid&ready
- out_spike  out  1  captured spike
- out_membrane  out  MEMBRANE_BITS  captured membrane
- spike_count  out  COUNT_BITS  spikes since reset, saturating
- load_error  out  1  sticky protocol-error flag

## Operation
- FSM states: IDLE, LOAD_W, LOAD_I. A beat counter `beat` runs 0..BEATS-1 and is shared by both load states.
- LOAD_W/LOAD_I beat, accepted:
  - in_data is written to shadow bits [beat*BUS_WIDTH +: BUS_WIDTH]. Loading is LSB-first: the first beat fills bits [BUS_WIDTH-1:0].
  - On beat BEATS-1: the shadow plus this beat is copied to weights or inputs in the same edge, `beat` returns to 0, and the FSM returns to IDLE.
  - The committed vectors never show a partial load.
- Op change mid-load (a LOAD_I beat while in LOAD_W with beat≠0, or the reverse):
  - The partial load is discarded and load_error is set.
  - The new beat is treated as beat 0 of the new target.
- STEP accepted:
  - neuron_enable=1 for exactly that cycle.
  - neuron_spike/neuron_membrane are registered into out_spike/out_membrane, and out_valid is set.
  - spike_count increments if the spike is 1; it saturates at all-ones.
  - If a load is partial, it is discarded, load_error is set, and the FSM goes to IDLE. The step uses the previously committed vectors.
- Reserved op accepted: no effect except load_error=1.
- load_error is cleared only by reset.
- in_ready = !out_valid | out_ready, for all ops. in_ready does not depend on in_valid or in_op.
- out_valid clears on out_ready when no STEP is accepted in the same cycle.
- Simultaneous out_ready and STEP acceptance: the result register reloads with the new result and out_valid stays 1.
- Reset values: weights=0, inputs=0, shadow=0, beat=0, IDLE, neuron_enable=0, out_valid=0, out_spike=0, out_membrane=0, spike_count=0, load_error=0.
- Reset mid-load discards all partial and committed data.

## Timing
- Vector commit: visible on weights/inputs the cycle after the final beat is accepted. Full load = BEATS accepted beats (4 at defaults).
- Step: neuron_enable is high in the acceptance cycle. out_valid is high from the next cycle.
- Back-to-back STEPs at 1/cycle are sustained while out_ready=1.
- A STEP in cycle t sees vectors committed at or before the edge ending t-1.
- All outputs are registered except in_ready and neuron_enable. neuron_enable = in_valid & in_ready & (in_op==STEP).

## Structure
- Package `neuron_feeder_pkg`: op-code localparams (OP_LOAD_W, OP_LOAD_I, OP_STEP, OP_RSVD) and the FSM state enum.
- Sub-module `beat_deserializer`:
  - Contains the shadow register and beat counter.
  - Inputs: load, clear, data. Outputs: full_vector and last-beat pulse.
  - One instance, shared by both targets; the top selects the commit destination.

## Test plan
- Load weights 0x11,0x22,0x33,0x44, then inputs 0xFF×4 -> weights=0x44332211, inputs=0xFFFFFFFF one cycle after the last beat; no intermediate values on the ports.
- LOAD_W 2 beats then STEP -> load_error=1, weights unchanged (0), neuron_enable for one cycle, out_valid next cycle.
- STEP with neuron_spike=1, membrane=5, out_ready=0, then a second STEP -> in_ready=0 and the second STEP is held; out_* stays {1,5}; spike_count=1.
- out_ready=1, STEP every cycle for 10 cycles with spike=1 -> 10 results, one per cycle; spike_count=10; no gaps.
- Saturation with COUNT_BITS=2 and 5 spiking STEPs -> spike_count=3.
- Reset asserted after 3 LOAD_I beats -> all outputs at reset values. A subsequent 4-beat load commits normally with load_error=0.
